// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key-code meanings
// and default timing parameters.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } scan_state_e;

  localparam int DEFAULT_SCAN_DIV       = 4000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 8;

  // Key codes are {row, col}; 0-9 are digits, A-F are calculator operations.
  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQU = 4'hF;

  function automatic logic [3:0] colDrive(input logic [1:0] idx);
    colDrive = ~(4'b0001 << idx);
  endfunction

  // Lowest-indexed low row wins when several keys share a column.
  function automatic logic [1:0] lowestLowRow(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the key-code handshake toward the calculator datapath.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keyCode;
  logic       keyLd;
  logic       keyHeld;

  modport master (
    input  row,
    output col,
    output keyCode,
    output keyLd,
    output keyHeld
  );

  modport slave (
    output row,
    input  col,
    input  keyCode,
    input  keyLd,
    input  keyHeld
  );
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks;
// shared with the display multiplexer.
module scan_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tick_o = (count_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce; emits one keyLd pulse per
// accepted press and holds keyHeld until the release is debounced.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  keypad_scanner_if.master         kp
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_TICKS);

  logic        tick;
  logic [3:0]  rowMeta_q, rowSync_q;
  scan_state_e state_q, state_d;
  logic [1:0]  colIdx_q, colIdx_d;
  logic [1:0]  candRow_q, candRow_d;
  logic [CW-1:0] count_q, count_d, countInc;
  logic [3:0]  keyCode_q, keyCode_d;
  logic        keyLd_q, keyLd_d;
  logic        keyHeld_q, keyHeld_d;
  logic [3:0]  col_q;
  logic        anyLow;
  logic [1:0]  lowRow;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign anyLow   = ~&rowSync_q;
  assign lowRow   = lowestLowRow(rowSync_q);
  assign countInc = count_q + 1'b1;

  // The column index only moves when the scan gives up on a column; it is
  // frozen while a candidate is being debounced or a key is held.
  always_comb begin
    state_d   = state_q;
    colIdx_d  = colIdx_q;
    candRow_d = candRow_q;
    count_d   = count_q;
    keyCode_d = keyCode_q;
    keyLd_d   = 1'b0;
    keyHeld_d = keyHeld_q;

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (anyLow) begin
            candRow_d = lowRow;
            if (DEBOUNCE_TICKS == 1) begin
              keyCode_d = {lowRow, colIdx_q};
              keyLd_d   = 1'b1;
              keyHeld_d = 1'b1;
              count_d   = '0;
              state_d   = ST_PRESSED;
            end else begin
              count_d = CW'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            colIdx_d = colIdx_q + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (anyLow && (lowRow == candRow_q)) begin
            if (countInc == TARGET) begin
              keyCode_d = {candRow_q, colIdx_q};
              keyLd_d   = 1'b1;
              keyHeld_d = 1'b1;
              count_d   = '0;
              state_d   = ST_PRESSED;
            end else begin
              count_d = countInc;
            end
          end else begin
            count_d  = '0;
            colIdx_d = colIdx_q + 2'd1;
            state_d  = ST_SCAN;
          end
        end

        ST_PRESSED: begin
          // Count now measures consecutive released ticks of the held key only.
          if (rowSync_q[candRow_q]) begin
            if (countInc == TARGET) begin
              keyHeld_d = 1'b0;
              count_d   = '0;
              colIdx_d  = colIdx_q + 2'd1;
              state_d   = ST_SCAN;
            end else begin
              count_d = countInc;
            end
          end else begin
            count_d = '0;
          end
        end

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
      state_q   <= ST_SCAN;
      colIdx_q  <= 2'd0;
      candRow_q <= 2'd0;
      count_q   <= '0;
      keyCode_q <= 4'h0;
      keyLd_q   <= 1'b0;
      keyHeld_q <= 1'b0;
      col_q     <= 4'b1110;
    end else begin
      rowMeta_q <= kp.row;
      rowSync_q <= rowMeta_q;
      state_q   <= state_d;
      colIdx_q  <= colIdx_d;
      candRow_q <= candRow_d;
      count_q   <= count_d;
      keyCode_q <= keyCode_d;
      keyLd_q   <= keyLd_d;
      keyHeld_q <= keyHeld_d;
      col_q     <= colDrive(colIdx_d);
    end
  end

  assign kp.col     = col_q;
  assign kp.keyCode = keyCode_q;
  assign kp.keyLd   = keyLd_q;
  assign kp.keyHeld = keyHeld_q;

endmodule
